re_order_buffer: RTL and testbench

RE_ORDER_BUFFER -- requirements
Module: re_order_buffer

---
 rtl/re_order_buffer_if.sv | 48 ++++
 rtl/re_order_buffer.sv | 108 ++++++++++
 tb/tb_re_order_buffer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/re_order_buffer_if.sv
// re_order_buffer_if: issue, CDB, operand-query and commit signals of the reorder buffer.
interface re_order_buffer_if #(
  parameter int ROBBW = 4,
  parameter int REGBW = 5
);
  logic             issue_flag;
  logic [1:0]       issue_type;
  logic [REGBW-1:0] issue_rd;
  logic             issue_pred;
  logic [ROBBW-1:0] next_id;
  logic             full;
  logic             ex_cdb_flag;
  logic [ROBBW-1:0] ex_cdb_rob_id;
  logic [31:0]      ex_cdb_val;
  logic             ex_cdb_jump;
  logic [31:0]      ex_cdb_pc;
  logic             ld_cdb_flag;
  logic [ROBBW-1:0] ld_cdb_rob_id;
  logic [31:0]      ld_cdb_val;
  logic [ROBBW-1:0] id1;
  logic [ROBBW-1:0] id2;
  logic             id1_ready;
  logic             id2_ready;
  logic [31:0]      id1_val;
  logic [31:0]      id2_val;
  logic             flag_ROB;
  logic [REGBW-1:0] rd_ROB;
  logic [ROBBW-1:0] id_ROB;
  logic [31:0]      val_ROB;
  logic             st_commit_flag;
  logic [ROBBW-1:0] st_commit_id;
  logic             jump_wrong;
  logic [31:0]      jump_pc;
  modport master (
    output issue_flag, issue_type, issue_rd, issue_pred,
    output ex_cdb_flag, ex_cdb_rob_id, ex_cdb_val, ex_cdb_jump, ex_cdb_pc,
    output ld_cdb_flag, ld_cdb_rob_id, ld_cdb_val, id1, id2,
    input  next_id, full, id1_ready, id2_ready, id1_val, id2_val,
    input  flag_ROB, rd_ROB, id_ROB, val_ROB, st_commit_flag, st_commit_id, jump_wrong, jump_pc
  );
  modport slave (
    input  issue_flag, issue_type, issue_rd, issue_pred,
    input  ex_cdb_flag, ex_cdb_rob_id, ex_cdb_val, ex_cdb_jump, ex_cdb_pc,
    input  ld_cdb_flag, ld_cdb_rob_id, ld_cdb_val, id1, id2,
    output next_id, full, id1_ready, id2_ready, id1_val, id2_val,
    output flag_ROB, rd_ROB, id_ROB, val_ROB, st_commit_flag, st_commit_id, jump_wrong, jump_pc
  );
endinterface

// File: rtl/re_order_buffer.sv
// re_order_buffer: circular in-order commit queue with CDB completion, operand query and mispredict flush.
module re_order_buffer #(
  parameter int ROBBW = 4,
  parameter int ROBSZ = 15,
  parameter int REGBW = 5
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  re_order_buffer_if.slave bus
);
  localparam int NE = 1 << ROBBW;
  logic [NE-1:0]    busy_q, ready_q, pred_q, jump_q;
  logic [1:0]       type_q [NE];
  logic [REGBW-1:0] ent_rd_q [NE];
  logic [31:0]      val_q [NE];
  logic [31:0]      pc_q [NE];
  logic [ROBBW-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic             flag_rob_q, st_flag_q, jw_q;
  logic [REGBW-1:0] rd_rob_q;
  logic [ROBBW-1:0] id_rob_q, st_id_q;
  logic [31:0]      val_rob_q, jpc_q;
  logic             commit, flush, issue, regw;
  function automatic logic [ROBBW-1:0] wrap(input logic [ROBBW-1:0] x);
    return x == ROBBW'(ROBSZ) ? ROBBW'(1) : x + 1'b1;
  endfunction
  assign bus.full    = count_q == ROBBW'(ROBSZ);
  assign bus.next_id = tail_q;
  assign commit = busy_q[head_q] & ready_q[head_q];
  // BR and JMP both have type bit 0 set; only they can redirect
  assign flush  = commit & type_q[head_q][0] & (jump_q[head_q] != pred_q[head_q]);
  assign issue  = bus.issue_flag & ~bus.full & ~flush;
  assign regw   = commit & (type_q[head_q][1] == type_q[head_q][0]);
  always_comb begin
    head_d  = flush ? ROBBW'(1) : commit ? wrap(head_q) : head_q;
    tail_d  = flush ? ROBBW'(1) : issue ? wrap(tail_q) : tail_q;
    count_d = flush ? '0 : count_q + ROBBW'(issue) - ROBBW'(commit);
  end
  assign bus.id1_ready = (bus.id1 != '0) && busy_q[bus.id1] && ready_q[bus.id1];
  assign bus.id2_ready = (bus.id2 != '0) && busy_q[bus.id2] && ready_q[bus.id2];
  assign bus.id1_val   = bus.id1_ready ? val_q[bus.id1] : '0;
  assign bus.id2_val   = bus.id2_ready ? val_q[bus.id2] : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= ROBBW'(1);
      tail_q  <= ROBBW'(1);
      count_q <= '0;
      busy_q  <= '0;
      ready_q <= '0;
    end else if (rdy) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (bus.ld_cdb_flag && busy_q[bus.ld_cdb_rob_id]) begin
        ready_q[bus.ld_cdb_rob_id] <= 1'b1;
        val_q[bus.ld_cdb_rob_id]   <= bus.ld_cdb_val;
      end
      if (bus.ex_cdb_flag && busy_q[bus.ex_cdb_rob_id]) begin
        ready_q[bus.ex_cdb_rob_id] <= 1'b1;
        val_q[bus.ex_cdb_rob_id]   <= bus.ex_cdb_val;
        jump_q[bus.ex_cdb_rob_id]  <= bus.ex_cdb_jump;
        pc_q[bus.ex_cdb_rob_id]    <= bus.ex_cdb_pc;
      end
      if (issue) begin
        busy_q[tail_q]   <= 1'b1;
        ready_q[tail_q]  <= 1'b0;
        type_q[tail_q]   <= bus.issue_type;
        ent_rd_q[tail_q] <= bus.issue_rd;
        pred_q[tail_q]   <= bus.issue_pred;
      end
      if (commit) busy_q[head_q] <= 1'b0;
      if (flush) begin
        busy_q  <= '0;
        ready_q <= '0;
      end
    end
  end
  // commit pulses are zeroed by reset and while stalled
  always_ff @(posedge clk) begin
    if (!rst || !rdy) begin
      flag_rob_q <= 1'b0;
      rd_rob_q   <= '0;
      id_rob_q   <= '0;
      val_rob_q  <= '0;
      st_flag_q  <= 1'b0;
      st_id_q    <= '0;
      jw_q       <= 1'b0;
      jpc_q      <= '0;
    end else begin
      flag_rob_q <= regw;
      rd_rob_q   <= regw ? ent_rd_q[head_q] : '0;
      id_rob_q   <= regw ? head_q : '0;
      val_rob_q  <= regw ? val_q[head_q] : '0;
      st_flag_q  <= commit && type_q[head_q] == 2'b10;
      st_id_q    <= commit && type_q[head_q] == 2'b10 ? head_q : '0;
      jw_q       <= flush;
      jpc_q      <= flush ? pc_q[head_q] : '0;
    end
  end
  assign bus.flag_ROB       = flag_rob_q;
  assign bus.rd_ROB         = rd_rob_q;
  assign bus.id_ROB         = id_rob_q;
  assign bus.val_ROB        = val_rob_q;
  assign bus.st_commit_flag = st_flag_q;
  assign bus.st_commit_id   = st_id_q;
  assign bus.jump_wrong     = jw_q;
  assign bus.jump_pc        = jpc_q;
endmodule

// File: tb/tb_re_order_buffer.sv
// tb_re_order_buffer: directed stimulus with a commit-event scoreboard checked by an independent monitor.
module tb_re_order_buffer;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic f; logic [4:0] rd; logic [3:0] id; logic [31:0] val;
    logic sf; logic [3:0] sid; logic jw; logic [31:0] jpc;
  } ev_t;
  ev_t exp_q[$];
  re_order_buffer_if #(.ROBBW(4), .REGBW(5)) bus ();
  re_order_buffer #(.ROBBW(4), .ROBSZ(15), .REGBW(5)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, got, exp);
    end
  endtask
  always @(negedge clk) begin
    ev_t got;
    got = {bus.flag_ROB, bus.rd_ROB, bus.id_ROB, bus.val_ROB, bus.st_commit_flag,
           bus.st_commit_id, bus.jump_wrong, bus.jump_pc};
    if (got !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit got %h exp none", got);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL commit_event got %h exp %h", got, e);
        end
      end
    end
  end
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle();
    bus.issue_flag = 0; bus.ex_cdb_flag = 0; bus.ld_cdb_flag = 0;
  endtask
  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic p);
    bus.issue_flag = 1; bus.issue_type = t; bus.issue_rd = rd; bus.issue_pred = p;
    tick(); idle();
  endtask
  task automatic set_ex(input logic [3:0] id, input logic [31:0] v, input logic j, input logic [31:0] pc);
    bus.ex_cdb_flag = 1; bus.ex_cdb_rob_id = id; bus.ex_cdb_val = v; bus.ex_cdb_jump = j; bus.ex_cdb_pc = pc;
  endtask
  task automatic set_ld(input logic [3:0] id, input logic [31:0] v);
    bus.ld_cdb_flag = 1; bus.ld_cdb_rob_id = id; bus.ld_cdb_val = v;
  endtask
  task automatic exp_reg(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] v);
    exp_q.push_back({1'b1, rd, id, v, 1'b0, 4'd0, 1'b0, 32'd0});
  endtask
  task automatic do_reset();
    rst = 0; idle(); tick(); tick(); rst = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
  initial begin
    idle();
    bus.issue_type = 0; bus.issue_rd = 0; bus.issue_pred = 0;
    bus.ex_cdb_rob_id = 0; bus.ex_cdb_val = 0; bus.ex_cdb_jump = 0; bus.ex_cdb_pc = 0;
    bus.ld_cdb_rob_id = 0; bus.ld_cdb_val = 0; bus.id1 = 0; bus.id2 = 0;
    do_reset();
    chk("reset_next_id", bus.next_id, 1);
    chk("reset_full", bus.full, 0);
    chk("reset_flag", bus.flag_ROB, 0);
    issue(2'b00, 5, 0);
    chk("issue_next_id", bus.next_id, 2);
    exp_reg(5, 1, 32'h1234);
    set_ex(1, 32'h1234, 0, 0); tick(); idle();
    tick();
    chk("basic_flag", bus.flag_ROB, 1);
    chk("basic_val", bus.val_ROB, 32'h1234);
    tick(); tick();
    do_reset();
    for (int i = 1; i <= 15; i++) issue(2'b00, 5'(i), 0);
    chk("fill_full", bus.full, 1);
    chk("fill_next_id", bus.next_id, 1);
    issue(2'b00, 31, 0);
    chk("ovf_full", bus.full, 1);
    chk("ovf_next_id", bus.next_id, 1);
    exp_reg(1, 1, 32'hAA);
    set_ex(1, 32'hAA, 0, 0); tick(); idle();
    tick();
    chk("drain_full", bus.full, 0);
    chk("drain_next_id", bus.next_id, 1);
    issue(2'b00, 20, 0);
    chk("reissue_next_id", bus.next_id, 2);
    chk("reissue_full", bus.full, 1);
    exp_reg(2, 2, 32'h22);
    set_ld(2, 32'h22); tick(); idle();
    tick(); tick(); tick();
    do_reset();
    issue(2'b01, 0, 0);
    issue(2'b00, 7, 0);
    exp_q.push_back({1'b0, 5'd0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 32'h100});
    set_ex(1, 0, 1, 32'h100); set_ld(2, 32'h55); tick(); idle();
    bus.issue_flag = 1; bus.issue_type = 2'b00; bus.issue_rd = 3;
    tick(); idle();
    chk("flush_jw", bus.jump_wrong, 1);
    chk("flush_pc", bus.jump_pc, 32'h100);
    chk("flush_next_id", bus.next_id, 1);
    tick();
    chk("flush_pulse_end", bus.jump_wrong, 0);
    bus.id1 = 2; #1;
    chk("flush_id2_gone", bus.id1_ready, 0);
    tick(); tick();
    issue(2'b00, 1, 0);
    issue(2'b00, 2, 0);
    issue(2'b00, 3, 0);
    issue(2'b10, 0, 0);
    issue(2'b01, 0, 1);
    set_ld(2, 32'h22); tick(); idle();
    bus.id1 = 2; bus.id2 = 1; #1;
    chk("q_id2_ready", bus.id1_ready, 1);
    chk("q_id2_val", bus.id1_val, 32'h22);
    chk("q_id1_notready", bus.id2_ready, 0);
    chk("q_id1_val0", bus.id2_val, 0);
    bus.id1 = 0; #1;
    chk("q_id0", bus.id1_ready, 0);
    exp_reg(1, 1, 32'h11); exp_reg(2, 2, 32'h22); exp_reg(3, 3, 7);
    set_ex(3, 7, 0, 0); set_ld(1, 32'h11); tick(); idle();
    bus.id1 = 3; #1;
    chk("q_id3_ready", bus.id1_ready, 1);
    chk("q_id3_val", bus.id1_val, 7);
    tick(); chk("order_1", bus.id_ROB, 1);
    tick(); chk("order_2", bus.id_ROB, 2);
    tick(); chk("order_3", bus.id_ROB, 3);
    exp_q.push_back({1'b0, 5'd0, 4'd0, 32'd0, 1'b1, 4'd4, 1'b0, 32'd0});
    set_ex(5, 0, 1, 32'h200); set_ld(4, 0); tick(); idle();
    tick();
    chk("st_flag", bus.st_commit_flag, 1);
    chk("st_id", bus.st_commit_id, 4);
    tick();
    chk("br_ok_no_jw", bus.jump_wrong, 0);
    issue(2'b11, 9, 1);
    exp_q.push_back({1'b1, 5'd9, 4'd6, 32'h60, 1'b0, 4'd0, 1'b1, 32'h300});
    set_ex(6, 32'h60, 0, 32'h300); tick(); idle();
    tick();
    chk("jmp_flush_next_id", bus.next_id, 1);
    chk("jmp_flag", bus.flag_ROB, 1);
    tick(); tick();
    issue(2'b00, 4, 0);
    set_ex(1, 32'h44, 0, 0); tick(); idle();
    rdy = 0;
    bus.issue_flag = 1; bus.issue_type = 2'b00; bus.issue_rd = 6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_flag", bus.flag_ROB, 0);
      chk("stall_next_id", bus.next_id, 2);
    end
    idle();
    rdy = 1;
    exp_reg(4, 1, 32'h44);
    tick();
    chk("unstall_flag", bus.flag_ROB, 1);
    tick(); tick();
    issue(2'b00, 8, 0);
    set_ex(2, 1, 0, 0); tick(); idle();
    rst = 0; tick(); rst = 1;
    chk("midreset_flag", bus.flag_ROB, 0);
    chk("midreset_next_id", bus.next_id, 1);
    tick(); tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
